mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-port `main` memory. It accepts read/write requests from two requesters (port 0, port 1), grants one at a time, and drives the memory's address, data and mode lines for a fixed access latency. It captures the read result and returns it with a one-cycle acknowledge. It sits between the requesters (fetch/load-store or cache refill logic) and `main`, and is the only block that drives the memory bus.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing one single-port memory.
// Each grant holds the memory bus for MEM_LATENCY cycles, then returns a one-cycle ack.
module mem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              mode0_i,
   input  logic              mode1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata0_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic              busy_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_mode_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [1:0]        state_o
);

   localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mode_q, mode_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              win;

   // On a tie the port that was not served last wins; otherwise the lone requester wins.
   assign win = (req0_i && req1_i) ? ~last_q : req1_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mode_d   = mode_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack0_o   = 1'b0;
      ack1_o   = 1'b0;
      mem_en_o = 1'b0;
      busy_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               gnt_d   = win;
               addr_d  = win ? addr1_i  : addr0_i;
               wdata_d = win ? wdata1_i : wdata0_i;
               mode_d  = win ? mode1_i  : mode0_i;
               cnt_d   = CNT_LOAD;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_en_o = 1'b1;
            busy_o   = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_RESP;
               if (!mode_q) begin
                  if (gnt_q) rdata1_d = mem_rdata_i;
                  else       rdata0_d = mem_rdata_i;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            busy_o  = 1'b1;
            ack0_o  = ~gnt_q;
            ack1_o  = gnt_q;
            last_d  = gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         last_q   <= 1'b1;
         gnt_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mode_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mode_q   <= mode_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign rdata0_o    = rdata0_q;
   assign rdata1_o    = rdata1_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_mode_o  = mode_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences, and a
// randomized phase checked against a transaction-timeline reference model.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   // ---------------- main DUT (MEM_LATENCY = 4) ----------------
   logic          req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, busy, mem_en, mem_mode;
   logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    state;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .req1_i(req1), .mode0_i(mode0), .mode1_i(mode1),
      .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
      .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
      .busy_o(busy), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_mode_o(mem_mode), .mem_rdata_i(mem_rdata),
      .state_o(state)
   );

   // ---------------- second DUT (MEM_LATENCY = 1) ----------------
   logic          d1_req0 = 1'b0, d1_req1 = 1'b0, d1_mode0 = 1'b0, d1_mode1 = 1'b0;
   logic [AW-1:0] d1_addr0 = '0, d1_addr1 = '0;
   logic [DW-1:0] d1_wdata0 = '0, d1_wdata1 = '0;
   logic          d1_ack0, d1_ack1, d1_busy, d1_mem_en, d1_mem_mode;
   logic [DW-1:0] d1_rdata0, d1_rdata1, d1_mem_wdata, d1_mem_rdata;
   logic [AW-1:0] d1_mem_addr;
   logic [1:0]    d1_state;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .req0_i(d1_req0), .req1_i(d1_req1), .mode0_i(d1_mode0), .mode1_i(d1_mode1),
      .addr0_i(d1_addr0), .addr1_i(d1_addr1), .wdata0_i(d1_wdata0), .wdata1_i(d1_wdata1),
      .ack0_o(d1_ack0), .ack1_o(d1_ack1), .rdata0_o(d1_rdata0), .rdata1_o(d1_rdata1),
      .busy_o(d1_busy), .mem_en_o(d1_mem_en), .mem_addr_o(d1_mem_addr),
      .mem_wdata_o(d1_mem_wdata), .mem_mode_o(d1_mem_mode), .mem_rdata_i(d1_mem_rdata),
      .state_o(d1_state)
   );

   // ---------------- memory models ----------------
   function automatic logic [DW-1:0] mem_init(input logic [3:0] i);
      return (i == 4'd4) ? 32'd25 : (32'h1000 + 32'(i) * 32'h11);
   endfunction

   logic [DW-1:0] mem_arr [16];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= mem_init(4'(i));
      end else if (mem_en && mem_mode) begin
         mem_arr[mem_addr[3:0]] <= mem_wdata;
      end
   end
   assign mem_rdata    = mem_arr[mem_addr[3:0]];
   assign d1_mem_rdata = mem_init(d1_mem_addr[3:0]);

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (timeline of granted transactions) ----------------
   typedef struct {
      int            g;      // edge number at which the grant happened
      bit            port;
      bit            mode;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } txn_t;

   txn_t          exp_q [$];
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] m_rd0, m_rd1;
   int            cyc = 0;
   int            m_free = 0;
   bit            m_last = 1'b1;
   bit            rand_on = 1'b0;
   txn_t          mt;

   // Each access occupies the bus for LAT+2 edges; grants alternate on ties.
   always @(posedge clk) begin
      cyc++;
      if (rand_on && cyc >= m_free && (req0 || req1)) begin
         mt.g     = cyc;
         mt.port  = (req0 && req1) ? !m_last : req1;
         mt.mode  = mt.port ? mode1 : mode0;
         mt.addr  = mt.port ? addr1 : addr0;
         mt.wdata = mt.port ? wdata1 : wdata0;
         mt.rdata = ref_mem[mt.addr[3:0]];
         if (mt.mode) ref_mem[mt.addr[3:0]] = mt.wdata;
         m_last = mt.port;
         m_free = cyc + LAT + 2;
         exp_q.push_back(mt);
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      bit            r0, r1, m0, m1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] w0, w1;
      bit            exp_port;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input bit r0, input bit r1, input bit m0, input bit m1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input bit ep, input logic [DW-1:0] er);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.m0 = m0; v.m1 = m1;
      v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
      v.exp_port = ep; v.exp_rdata = er;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d1_req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int max, output int lat, output bit port);
      lat = 0; port = 1'b0;
      for (int k = 1; k <= max; k++) begin
         @(negedge clk);
         if (ack0 && ack1) chk("both_acks", 2'b11, 2'b00);
         if (ack0 || ack1) begin
            lat = k; port = ack1;
            break;
         end
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int en_cnt = 0;
      int lat = 0;
      @(negedge clk);
      req0 = v.r0; req1 = v.r1; mode0 = v.m0; mode1 = v.m1;
      addr0 = v.a0; addr1 = v.a1; wdata0 = v.w0; wdata1 = v.w1;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(negedge clk);
         if (mem_en) begin
            en_cnt++;
            if (en_cnt == 1) begin
               chk($sformatf("v%0d_bus_addr", idx), mem_addr, v.exp_port ? v.a1 : v.a0);
               chk($sformatf("v%0d_bus_mode", idx), mem_mode, v.exp_port ? v.m1 : v.m0);
               chk($sformatf("v%0d_bus_wdata", idx), mem_wdata, v.exp_port ? v.w1 : v.w0);
            end
         end
         if (ack0 || ack1) begin
            lat = k;
            chk($sformatf("v%0d_ack_port", idx), {ack1, ack0}, v.exp_port ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_busy_in_ack", idx), busy, 1'b1);
            chk($sformatf("v%0d_rdata", idx), v.exp_port ? rdata1 : rdata0, v.exp_rdata);
            break;
         end
      end
      chk($sformatf("v%0d_ack_latency", idx), lat, LAT + 1);
      chk($sformatf("v%0d_en_cycles", idx), en_cnt, LAT);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", idx), busy, 1'b0);
   endtask

   task automatic run_random(input int n);
      txn_t t;
      bit   e_en, e_busy, e_a0, e_a1;
      do_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(4'(i));
      m_free = 0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
      exp_q.delete();
      rand_on = 1'b1;
      for (int i = 0; i < n + 3 * LAT + 10; i++) begin
         @(negedge clk);
         e_en = 1'b0; e_busy = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0;
         if (exp_q.size() > 0) begin
            t      = exp_q[0];
            e_en   = (cyc >= t.g) && (cyc < t.g + LAT);
            e_busy = (cyc >= t.g) && (cyc <= t.g + LAT);
            if (cyc == t.g + LAT) begin
               e_a0 = !t.port;
               e_a1 = t.port;
            end
         end
         chk("rnd_mem_en", mem_en, e_en);
         chk("rnd_busy", busy, e_busy);
         chk("rnd_ack0", ack0, e_a0);
         chk("rnd_ack1", ack1, e_a1);
         if (e_en) begin
            chk("rnd_bus_addr", mem_addr, t.addr);
            chk("rnd_bus_mode", mem_mode, t.mode);
            chk("rnd_bus_wdata", mem_wdata, t.wdata);
         end
         if (e_a0 || e_a1) begin
            if (!t.mode) begin
               if (t.port) m_rd1 = t.rdata;
               else        m_rd0 = t.rdata;
            end
            chk("rnd_rdata0", rdata0, m_rd0);
            chk("rnd_rdata1", rdata1, m_rd1);
            exp_q.pop_front();
         end
         // Requesters: drop (or reissue back-to-back) on ack, otherwise raise at random.
         if (ack0) begin
            req0 = (i < n) && ($urandom_range(0, 3) == 0);
            mode0 = 1'($urandom_range(0, 1)); addr0 = $urandom(); wdata0 = $urandom();
         end else if (!req0 && i < n && $urandom_range(0, 3) == 0) begin
            req0 = 1'b1;
            mode0 = 1'($urandom_range(0, 1)); addr0 = $urandom(); wdata0 = $urandom();
         end
         if (ack1) begin
            req1 = (i < n) && ($urandom_range(0, 3) == 0);
            mode1 = 1'($urandom_range(0, 1)); addr1 = $urandom(); wdata1 = $urandom();
         end else if (!req1 && i < n && $urandom_range(0, 3) == 0) begin
            req1 = 1'b1;
            mode1 = 1'($urandom_range(0, 1)); addr1 = $urandom(); wdata1 = $urandom();
         end
      end
      chk("rnd_queue_drained", exp_q.size(), 0);
      rand_on = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      int  lat;
      bit  port;
      int  ta [4];
      bit  pa [4];
      int  n_acks;
      bit  saw_ack0;

      // After reset mem[4] (addr 100) = 25; ties start with port 0.
      vecs[0] = mk(1, 0, 0, 0, 100, 0,   0,            0,  0, 32'd25);
      vecs[1] = mk(0, 1, 0, 1, 0,   100, 0,            55, 1, 32'd0);
      vecs[2] = mk(0, 1, 0, 0, 0,   100, 0,            0,  1, 32'd55);
      vecs[3] = mk(1, 1, 0, 0, 3,   5,   0,            0,  0, mem_init(4'd3));
      vecs[4] = mk(1, 1, 0, 0, 6,   5,   0,            0,  1, mem_init(4'd5));
      vecs[5] = mk(1, 1, 1, 0, 7,   100, 32'hDEADBEEF, 0,  0, mem_init(4'd3));
      vecs[6] = mk(0, 1, 0, 0, 0,   7,   0,            0,  1, 32'hDEADBEEF);
      vecs[7] = mk(1, 0, 0, 0, 7,   0,   0,            0,  0, 32'hDEADBEEF);

      // Reset state of both instances.
      do_reset();
      chk("rst_outputs", {ack0, ack1, busy, mem_en, mem_mode, state}, '0);
      chk("rst_bus_addr", mem_addr, 0);
      chk("rst_bus_wdata", mem_wdata, 0);
      chk("rst_rdata", {rdata0, rdata1}, 0);
      chk("rst_d1_outputs", {d1_ack0, d1_ack1, d1_busy, d1_mem_en, d1_state, d1_rdata0}, 0);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Continuous contention after reset: 0,1,0,1 with LAT+2 spacing.
      do_reset();
      req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0; addr0 = 1; addr1 = 2;
      n_acks = 0;
      for (int k = 1; k <= 5 * (LAT + 2) && n_acks < 4; k++) begin
         @(negedge clk);
         if (ack0 && ack1) chk("cont_both_acks", 2'b11, 2'b00);
         if (ack0 || ack1) begin
            ta[n_acks] = k; pa[n_acks] = ack1; n_acks++;
         end
      end
      chk("cont_ack_count", n_acks, 4);
      chk("cont_order", {pa[0], pa[1], pa[2], pa[3]}, 4'b0101);
      chk("cont_first_lat", ta[0], LAT + 1);
      chk("cont_gap1", ta[1] - ta[0], LAT + 2);
      chk("cont_gap3", ta[3] - ta[2], LAT + 2);
      chk("cont_rdata0", rdata0, mem_init(4'd1));
      chk("cont_rdata1", rdata1, mem_init(4'd2));
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);

      // Reset in the third BUSY cycle: no ack, all outputs cleared, then normal service.
      req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0; addr0 = 100; addr1 = 9;
      repeat (3) @(negedge clk);
      chk("rmid_busy_before", mem_en, 1'b1);
      chk("rmid_addr_before", mem_addr, 100);
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_outputs", {ack0, ack1, busy, mem_en, mem_mode, state}, '0);
      chk("rmid_bus", {mem_addr, mem_wdata}, 0);
      chk("rmid_rdata", {rdata0, rdata1}, 0);
      rst = 1'b0; req0 = 1'b0;
      wait_ack(LAT + 4, lat, port);
      chk("rmid_req1_lat", lat, LAT + 1);
      chk("rmid_req1_port", port, 1'b1);
      chk("rmid_req1_rdata", rdata1, mem_init(4'd9));
      req1 = 1'b0;
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(LAT + 4, lat, port);
      chk("rmid_tie_port", port, 1'b0);
      chk("rmid_tie_lat", lat, LAT + 1);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);

      // Requester drops req in the second BUSY cycle; port 1 arrives while busy.
      do_reset();
      req0 = 1'b1; mode0 = 1'b0; addr0 = 100;
      @(negedge clk);
      req1 = 1'b1; mode1 = 1'b0; addr1 = 32'h14;
      @(negedge clk);
      req0 = 1'b0;
      wait_ack(LAT + 4, lat, port);
      chk("drop_ack_lat", lat, LAT - 1);
      chk("drop_ack_port", port, 1'b0);
      chk("drop_rdata0", rdata0, 32'd25);
      wait_ack(LAT + 6, lat, port);
      chk("drop_next_lat", lat, LAT + 2);
      chk("drop_next_port", port, 1'b1);
      chk("drop_next_rdata1", rdata1, 32'd25);
      req1 = 1'b0;
      @(negedge clk);

      // MEM_LATENCY = 1 instance.
      d1_req0 = 1'b1; d1_mode0 = 1'b0; d1_addr0 = 5;
      @(negedge clk);
      chk("lat1_en_c1", {d1_mem_en, d1_ack0}, 2'b10);
      chk("lat1_addr", d1_mem_addr, 5);
      @(negedge clk);
      chk("lat1_en_c2", {d1_mem_en, d1_ack0, d1_busy}, 3'b011);
      chk("lat1_rdata", d1_rdata0, mem_init(4'd5));
      d1_req0 = 1'b0;
      @(negedge clk);
      chk("lat1_idle", {d1_busy, d1_ack0, d1_ack1}, 3'b000);

      run_random(3000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
